// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and x1..x31 zero-init sweep for the register file write port.
// Define REGFILE_WB_ARB_FWD_EN to build the write-to-read forwarding compares.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              o_init_busy,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  input  logic [ADDR_W-1:0] i_rd1_addr,
  input  logic [ADDR_W-1:0] i_rd2_addr,
  output logic              o_fwd1_valid,
  output logic [DATA_W-1:0] o_fwd1_data,
  output logic              o_fwd2_valid,
  output logic [DATA_W-1:0] o_fwd2_data
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic              w_contend;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_INIT: if (r_cnt == LAST) w_state_nxt = S_RUN;
      S_RUN:  w_state_nxt = S_RUN;
    endcase
  end

  // Reset gates the grant so a request at the reset edge is never acked.
  always_comb begin
    o_init_busy = (r_state == S_INIT);
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    if (r_state == S_RUN && !reset) begin
      w_gnt0 = i_req0_valid & (~i_req1_valid | ~r_ptr);
      w_gnt1 = i_req1_valid & (~i_req0_valid |  r_ptr);
    end
  end

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;
  assign w_xfer       = w_gnt0 | w_gnt1;
  assign w_contend    = w_xfer & i_req0_valid & i_req1_valid;
  assign w_addr       = w_gnt1 ? i_req1_addr : i_req0_addr;
  assign w_data       = w_gnt1 ? i_req1_data : i_req0_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= ADDR_W'(1);
      r_ptr   <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_state == S_INIT) begin
        r_we    <= 1'b1;
        r_waddr <= r_cnt;
        r_wdata <= '0;
        r_cnt   <= r_cnt + 1'b1;
      end else if (w_xfer && w_addr != '0) begin
        r_we    <= 1'b1;
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
      if (w_contend) r_ptr <= ~r_ptr;
    end
  end

  assign o_rf_we    = r_we;
  assign o_rf_waddr = r_waddr;
  assign o_rf_wdata = r_wdata;

`ifdef REGFILE_WB_ARB_FWD_EN
  assign o_fwd1_valid = r_we & (r_waddr == i_rd1_addr) & (i_rd1_addr != '0);
  assign o_fwd2_valid = r_we & (r_waddr == i_rd2_addr) & (i_rd2_addr != '0);
  assign o_fwd1_data  = r_wdata;
  assign o_fwd2_data  = r_wdata;
`else
  logic w_unused_rd;
  assign w_unused_rd  = ^{i_rd1_addr, i_rd2_addr};
  assign o_fwd1_valid = 1'b0;
  assign o_fwd2_valid = 1'b0;
  assign o_fwd1_data  = '0;
  assign o_fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: init sweep, round-robin, x0 drop,
// mid-stream reset and forwarding (REGFILE_WB_ARB_FWD_EN aware).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_busy;
  logic        v0, v1, rdy0, rdy1;
  logic [4:0]  a0, a1, rd1, rd2;
  logic [31:0] d0, d1;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        f1v, f2v;
  logic [31:0] f1d, f2d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .o_init_busy  (init_busy),
    .i_req0_valid (v0),
    .i_req0_addr  (a0),
    .i_req0_data  (d0),
    .o_req0_ready (rdy0),
    .i_req1_valid (v1),
    .i_req1_addr  (a1),
    .i_req1_data  (d1),
    .o_req1_ready (rdy1),
    .o_rf_we      (we),
    .o_rf_waddr   (waddr),
    .o_rf_wdata   (wdata),
    .i_rd1_addr   (rd1),
    .i_rd2_addr   (rd2),
    .o_fwd1_valid (f1v),
    .o_fwd1_data  (f1d),
    .o_fwd2_valid (f2v),
    .o_fwd2_data  (f2d)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    rd1 = 0; rd2 = 0;
    repeat (3) step();
    chk("rst_we", 32'(we), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", 32'(init_busy), 1);
    chk("rst_fwd1", 32'(f1v), 0);

    // Held-off request during INIT
    reset = 1'b0;
    v0 = 1; a0 = 5'd9; d0 = 32'h99;
    #1;
    chk("init_rdy0_first", 32'(rdy0), 0);
    for (int k = 1; k <= 31; k++) begin
      step();
      chk($sformatf("init_we_%0d", k), 32'(we), 1);
      chk($sformatf("init_waddr_%0d", k), 32'(waddr), 32'(k));
      chk($sformatf("init_wdata_%0d", k), wdata, 0);
      chk($sformatf("init_busy_%0d", k), 32'(init_busy), (k < 31) ? 1 : 0);
      chk($sformatf("init_rdy0_%0d", k), 32'(rdy0), (k < 31) ? 0 : 1);
    end
    step();
    chk("held_we", 32'(we), 1);
    chk("held_waddr", 32'(waddr), 9);
    chk("held_wdata", wdata, 32'h99);
    v0 = 0;
    step();
    chk("idle_we", 32'(we), 0);
    chk("idle_waddr_hold", 32'(waddr), 9);
    chk("idle_wdata_hold", wdata, 32'h99);

    // Single ALU request
    v0 = 1; a0 = 5'd5; d0 = 32'h2A;
    #1;
    chk("t2_rdy0", 32'(rdy0), 1);
    chk("t2_rdy1", 32'(rdy1), 0);
    step();
    chk("t2_we", 32'(we), 1);
    chk("t2_waddr", 32'(waddr), 5);
    chk("t2_wdata", wdata, 32'h2A);

    // Forwarding of a write to x7
    a0 = 5'd7; d0 = 32'h11; rd1 = 5'd7; rd2 = 5'd0;
    step();
    v0 = 0;
`ifdef REGFILE_WB_ARB_FWD_EN
    chk("fwd1_valid", 32'(f1v), 1);
    chk("fwd1_data", f1d, 32'h11);
`else
    chk("fwd1_valid", 32'(f1v), 0);
    chk("fwd1_data", f1d, 0);
`endif
    chk("fwd2_valid", 32'(f2v), 0);
    rd2 = 5'd7;
    #1;
`ifdef REGFILE_WB_ARB_FWD_EN
    chk("fwd2_valid_x7", 32'(f2v), 1);
`else
    chk("fwd2_valid_x7", 32'(f2v), 0);
`endif
    step();
    chk("fwd1_idle", 32'(f1v), 0);
    rd1 = 0; rd2 = 0;

    // Contended round robin, pointer starts at 0
    v0 = 1; a0 = 5'd3; d0 = 32'h33;
    v1 = 1; a1 = 5'd4; d1 = 32'h44;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_rdy0_%0d", i), 32'(rdy0), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_rdy1_%0d", i), 32'(rdy1), (i % 2 == 0) ? 0 : 1);
      step();
      chk($sformatf("rr_we_%0d", i), 32'(we), 1);
      chk($sformatf("rr_waddr_%0d", i), 32'(waddr), (i % 2 == 0) ? 3 : 4);
      chk($sformatf("rr_wdata_%0d", i), wdata,
          (i % 2 == 0) ? 32'h33 : 32'h44);
    end
    v0 = 0; v1 = 0;

    // x0 write accepted but dropped
    v1 = 1; a1 = 5'd0; d1 = 32'hFFFFFFFF;
    #1;
    chk("x0_rdy1", 32'(rdy1), 1);
    chk("x0_rdy0", 32'(rdy0), 0);
    step();
    chk("x0_we", 32'(we), 0);

    // Uncontended req1 must not move the pointer
    a1 = 5'd6; d1 = 32'h66;
    #1;
    chk("unc_rdy1", 32'(rdy1), 1);
    step();
    chk("unc_waddr", 32'(waddr), 6);
    chk("unc_wdata", wdata, 32'h66);
    v0 = 1; a0 = 5'd3; d0 = 32'h33;
    a1 = 5'd4; d1 = 32'h44;
    #1;
    chk("ptr_hold_rdy0", 32'(rdy0), 1);
    chk("ptr_hold_rdy1", 32'(rdy1), 0);
    step();
    chk("ptr_hold_waddr", 32'(waddr), 3);
    #1;
    chk("ptr_flip_rdy1", 32'(rdy1), 1);

    // Mid-stream reset with both requests valid
    reset = 1'b1;
    #1;
    chk("mrst_rdy0", 32'(rdy0), 0);
    chk("mrst_rdy1", 32'(rdy1), 0);
    step();
    chk("mrst_we", 32'(we), 0);
    chk("mrst_waddr", 32'(waddr), 0);
    chk("mrst_wdata", wdata, 0);
    chk("mrst_busy", 32'(init_busy), 1);
    reset = 1'b0;
    #1;
    chk("mrst_rdy0_init", 32'(rdy0), 0);
    step();
    chk("mrst_sweep_we", 32'(we), 1);
    chk("mrst_sweep_waddr1", 32'(waddr), 1);
    chk("mrst_sweep_wdata1", wdata, 0);
    chk("mrst_sweep_rdy1", 32'(rdy1), 0);
    step();
    chk("mrst_sweep_waddr2", 32'(waddr), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
